// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: turns an EX/MEM load/store into a single
// registered data-memory request, waits for the acknowledge (or aborts after
// MAX_WAIT cycles), and hands the extended load result to MEM/WB.
module mem_access_stage #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_mem,
    input  logic        mem_write_mem,
    input  logic [2:0]  funct3_mem,
    input  logic [31:0] alu_result_mem,
    input  logic [31:0] rs2_data_mem,
    input  logic        stall_in,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    output logic [31:0] mem2reg_data,
    output logic        stall_mem,
    output logic        misaligned_exc,
    output logic        bus_err
);

    // Counter value seen in the last BUSY cycle allowed before the abort.
    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_next;
    logic [7:0]  wait_cnt;
    logic        mem_access, misaligned, start, ack_hit, timeout;
    logic        is_load_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;

    // Byte enables for a store of the size encoded in funct3 at byte offset off.
    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   lane_be = 4'b0001 << off;
            2'b01:   lane_be = 4'b0011 << {off[1], 1'b0};
            default: lane_be = 4'b1111;
        endcase
    endfunction

    // Store data replicated across all lanes so the enabled lanes see it.
    function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] rs2);
        case (f3[1:0])
            2'b00:   lane_data = {4{rs2[7:0]}};
            2'b01:   lane_data = {2{rs2[15:0]}};
            default: lane_data = rs2;
        endcase
    endfunction

    // Pick the addressed byte/half out of the read word and extend it.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  load_extend = {{24{b[7]}}, b};
            3'b001:  load_extend = {{16{h[15]}}, h};
            3'b100:  load_extend = {24'd0, b};
            3'b101:  load_extend = {16'd0, h};
            default: load_extend = word;
        endcase
    endfunction

    assign mem_access = mem_read_mem | mem_write_mem;
    assign misaligned = ((funct3_mem[1:0] == 2'b01) && alu_result_mem[0]) ||
                        (funct3_mem[1] && (alu_result_mem[1:0] != 2'b00));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state decode plus the combinational stall and exception flags.
    always_comb begin
        state_next     = state;
        stall_mem      = 1'b0;
        misaligned_exc = 1'b0;
        start          = 1'b0;
        ack_hit        = 1'b0;
        timeout        = 1'b0;
        case (state)
            IDLE: begin
                if (mem_access) begin
                    if (misaligned) begin
                        misaligned_exc = 1'b1;
                    end else begin
                        stall_mem  = 1'b1;
                        start      = 1'b1;
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                stall_mem = 1'b1;
                if (dmem_ack) begin
                    ack_hit    = 1'b1;
                    state_next = DONE;
                end else if (wait_cnt == LAST_WAIT) begin
                    timeout    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!stall_in) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request registers, wait counter, load buffer and bus-error pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            dmem_be      <= '0;
            mem2reg_data <= '0;
            bus_err      <= 1'b0;
            wait_cnt     <= '0;
            is_load_q    <= 1'b0;
            f3_q         <= '0;
            off_q        <= '0;
        end else begin
            bus_err <= timeout;
            if (start) begin
                dmem_req   <= 1'b1;
                dmem_we    <= mem_write_mem;
                dmem_addr  <= {alu_result_mem[31:2], 2'b00};
                dmem_wdata <= lane_data(funct3_mem, rs2_data_mem);
                dmem_be    <= lane_be(funct3_mem, alu_result_mem[1:0]);
                is_load_q  <= mem_read_mem & ~mem_write_mem;
                f3_q       <= funct3_mem;
                off_q      <= alu_result_mem[1:0];
                wait_cnt   <= '0;
            end
            if (state == BUSY && !dmem_ack) wait_cnt <= wait_cnt + 8'd1;
            if (ack_hit || timeout) dmem_req <= 1'b0;
            if (ack_hit && is_load_q) mem2reg_data <= load_extend(f3_q, off_q, dmem_rdata);
            if (timeout && is_load_q) mem2reg_data <= '0;
        end
    end

endmodule
